// File: rtl/npu_pkg.sv
// Shared types for the GEMM post-processing scheduler: ACC bank states,
// queued post-processing commands and the issue FSM states.
package npu_pkg;

    // Command bank field is sized for the largest supported pool (4 banks).
    localparam int PP_BANK_W = 2;

    typedef enum logic [1:0] {
        BANK_FREE     = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_READY    = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    typedef struct packed {
        logic [PP_BANK_W-1:0] bank;
        logic [7:0]           flags;
        logic [7:0]           scale;
        logic [7:0]           shift;
    } pp_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/pp_cmd_fifo.sv
// In-order queue of pending post-processing commands; push and pop may
// happen in the same cycle, and clear empties it in one cycle.
module pp_cmd_fifo
    import npu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  pp_cmd_t       din,
    input  logic          pop,
    output pp_cmd_t       dout,
    output logic [AW:0]   count
);

    pp_cmd_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/gemm_post_sched.sv
// Sequences the post-processing unit over a pool of ACC banks.
//   state | meaning
//   IDLE  | waiting for a queued tile
//   ISSUE | pp command valid, waiting for pp_cmd_ready
//   RUN   | post-processor busy, watchdog counting
module gemm_post_sched
    import npu_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = $clog2(NUM_BANKS),
    parameter int QDEPTH    = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [BANK_W-1:0] alloc_bank,
    input  logic              tile_valid,
    output logic              tile_ready,
    input  logic [BANK_W-1:0] tile_bank,
    input  logic [7:0]        tile_flags,
    input  logic [7:0]        tile_scale,
    input  logic [7:0]        tile_shift,
    output logic              pp_cmd_valid,
    input  logic              pp_cmd_ready,
    output logic [7:0]        pp_flags,
    output logic [7:0]        pp_scale,
    output logic [7:0]        pp_shift,
    output logic [BANK_W-1:0] pp_bank,
    input  logic              pp_done,
    input  logic              flush,
    output logic              sched_busy,
    output logic [BANK_W:0]   free_cnt,
    output logic              err_timeout,
    output logic              err_proto
);

    localparam int QW   = $clog2(QDEPTH) + 1;
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [QW-1:0]   QDEPTH_C = QW'(QDEPTH);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    bank_state_t       bank_st     [NUM_BANKS];
    bank_state_t       bank_st_nxt [NUM_BANKS];
    pp_cmd_t           fifo_din;
    pp_cmd_t           fifo_dout;
    pp_cmd_t           pp_cmd_q;
    logic [QW-1:0]     q_count;
    logic [WD_W-1:0]   wd_cnt;

    logic              any_free;
    logic [BANK_W-1:0] free_idx;
    logic              tile_acc;
    logic              tile_ok;
    logic              push;
    logic              pop;
    logic              run_entry;
    logic              drain_free;
    logic              wd_expire;

    // Lowest-index free bank and free count, from registered state only.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        free_cnt = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (bank_st[i] == BANK_FREE) begin
                any_free = 1'b1;
                free_idx = BANK_W'(i);
                free_cnt = free_cnt + (BANK_W+1)'(1);
            end
        end
    end

    always_comb begin
        tile_ok = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (tile_bank == BANK_W'(i) && bank_st[i] == BANK_FILLING) begin
                tile_ok = 1'b1;
            end
        end
    end

    assign alloc_gnt  = alloc_req & any_free & ~flush;
    assign alloc_bank = free_idx;
    assign tile_ready = (q_count < QDEPTH_C) & ~flush;
    assign tile_acc   = tile_valid & tile_ready;
    assign push       = tile_acc & tile_ok;

    always_comb begin
        fifo_din       = '0;
        fifo_din.bank  = PP_BANK_W'(tile_bank);
        fifo_din.flags = tile_flags;
        fifo_din.scale = tile_scale;
        fifo_din.shift = tile_shift;
    end

    pp_cmd_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (q_count)
    );

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        run_entry  = 1'b0;
        drain_free = 1'b0;
        wd_expire  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Flush empties the queue this cycle, so nothing may be popped.
                if (q_count != '0 && !flush) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (pp_cmd_ready) begin
                    run_entry = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pp_done) begin
                    drain_free = 1'b1;
                    state_nxt  = ST_IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    wd_expire  = 1'b1;
                    drain_free = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Each event touches a bank in a distinct state, so at most one applies.
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_st_nxt[i] = bank_st[i];
            if (alloc_gnt && free_idx == BANK_W'(i)) begin
                bank_st_nxt[i] = BANK_FILLING;
            end
            if (push && tile_bank == BANK_W'(i)) begin
                bank_st_nxt[i] = BANK_READY;
            end
            if (pop && fifo_dout.bank == PP_BANK_W'(i)) begin
                bank_st_nxt[i] = BANK_DRAINING;
            end
            if (drain_free && pp_cmd_q.bank == PP_BANK_W'(i)) begin
                bank_st_nxt[i] = BANK_FREE;
            end
            if (flush && (bank_st[i] == BANK_FILLING || bank_st[i] == BANK_READY)) begin
                bank_st_nxt[i] = BANK_FREE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pp_cmd_q    <= '0;
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_st[i] <= BANK_FREE;
            end
        end else begin
            state <= state_nxt;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_st[i] <= bank_st_nxt[i];
            end
            if (pop) begin
                pp_cmd_q <= fifo_dout;
            end
            if (run_entry) begin
                wd_cnt <= '0;
            end else if (state == ST_RUN) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_expire) begin
                err_timeout <= 1'b1;
            end
            if ((tile_acc && !tile_ok) || (pp_done && state != ST_RUN)) begin
                err_proto <= 1'b1;
            end
        end
    end

    assign pp_cmd_valid = (state == ST_ISSUE);
    assign pp_bank      = pp_cmd_q.bank[BANK_W-1:0];
    assign pp_flags     = pp_cmd_q.flags;
    assign pp_scale     = pp_cmd_q.scale;
    assign pp_shift     = pp_cmd_q.shift;
    assign sched_busy   = (state != ST_IDLE) || (q_count != '0);

endmodule

// File: tb/tb_gemm_post_sched.sv
// Directed bench for gemm_post_sched: two banks, 4-deep queue, 16-cycle watchdog.
module tb_gemm_post_sched;

    localparam int NB = 2;
    localparam int BW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_req;
    logic          alloc_gnt;
    logic [BW-1:0] alloc_bank;
    logic          tile_valid;
    logic          tile_ready;
    logic [BW-1:0] tile_bank;
    logic [7:0]    tile_flags;
    logic [7:0]    tile_scale;
    logic [7:0]    tile_shift;
    logic          pp_cmd_valid;
    logic          pp_cmd_ready;
    logic [7:0]    pp_flags;
    logic [7:0]    pp_scale;
    logic [7:0]    pp_shift;
    logic [BW-1:0] pp_bank;
    logic          pp_done;
    logic          flush;
    logic          sched_busy;
    logic [BW:0]   free_cnt;
    logic          err_timeout;
    logic          err_proto;

    int n_checks = 0;
    int n_fail   = 0;

    gemm_post_sched #(
        .NUM_BANKS (NB),
        .QDEPTH    (4),
        .TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_bank   (alloc_bank),
        .tile_valid   (tile_valid),
        .tile_ready   (tile_ready),
        .tile_bank    (tile_bank),
        .tile_flags   (tile_flags),
        .tile_scale   (tile_scale),
        .tile_shift   (tile_shift),
        .pp_cmd_valid (pp_cmd_valid),
        .pp_cmd_ready (pp_cmd_ready),
        .pp_flags     (pp_flags),
        .pp_scale     (pp_scale),
        .pp_shift     (pp_shift),
        .pp_bank      (pp_bank),
        .pp_done      (pp_done),
        .flush        (flush),
        .sched_busy   (sched_busy),
        .free_cnt     (free_cnt),
        .err_timeout  (err_timeout),
        .err_proto    (err_proto)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tile(input logic [BW-1:0] b, input logic [7:0] f,
                            input logic [7:0] sc, input logic [7:0] sh);
        tile_valid = 1'b1;
        tile_bank  = b;
        tile_flags = f;
        tile_scale = sc;
        tile_shift = sh;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; alloc_req = 1'b0; tile_valid = 1'b0; tile_bank = '0;
        tile_flags = '0; tile_scale = '0; tile_shift = '0;
        pp_cmd_ready = 1'b0; pp_done = 1'b0; flush = 1'b0;
        cyc(); cyc();
        rst = 1'b0; #1;

        check_val("rst_free_cnt", free_cnt, 2);
        check_val("rst_tile_ready", tile_ready, 1);
        check_val("rst_valid", pp_cmd_valid, 0);
        check_val("rst_busy", sched_busy, 0);
        check_val("rst_errs", {err_timeout, err_proto}, 0);
        check_val("rst_pp_fields", {pp_flags, pp_scale, pp_shift, 7'b0, pp_bank}, 0);

        // allocation: bank 0, bank 1, then exhausted
        alloc_req = 1'b1; #1;
        check_val("alloc0_gnt", alloc_gnt, 1);
        check_val("alloc0_bank", alloc_bank, 0);
        check_val("alloc0_free", free_cnt, 2);
        cyc();
        check_val("alloc1_gnt", alloc_gnt, 1);
        check_val("alloc1_bank", alloc_bank, 1);
        check_val("alloc1_free", free_cnt, 1);
        cyc();
        check_val("alloc2_gnt", alloc_gnt, 0);
        check_val("alloc2_free", free_cnt, 0);
        alloc_req = 1'b0;

        // tile handover on bank 0, issue two cycles after accept
        set_tile(1'b0, 8'h07, 8'd3, 8'd4); #1;
        check_val("tile0_ready", tile_ready, 1);
        cyc();
        tile_valid = 1'b0; #1;
        check_val("issue_lat1_valid", pp_cmd_valid, 0);
        check_val("issue_lat1_busy", sched_busy, 1);
        cyc();
        check_val("issue_valid", pp_cmd_valid, 1);
        check_val("issue_bank", pp_bank, 0);
        check_val("issue_flags", pp_flags, 8'h07);
        check_val("issue_scale", pp_scale, 3);
        check_val("issue_shift", pp_shift, 4);

        // hold ready low; queue bank 1 meanwhile
        set_tile(1'b1, 8'h21, 8'd5, 8'd6);
        for (int i = 0; i < 5; i++) begin
            cyc();
            tile_valid = 1'b0; #1;
            check_val("hold_valid", pp_cmd_valid, 1);
            check_val("hold_fields", {pp_flags, pp_scale, pp_shift, 7'b0, pp_bank}, {8'h07, 8'd3, 8'd4, 8'd0});
        end

        pp_cmd_ready = 1'b1;
        cyc();
        pp_cmd_ready = 1'b0; #1;
        check_val("run_valid_low", pp_cmd_valid, 0);
        check_val("run_fields", {pp_flags, 7'b0, pp_bank}, {8'h07, 8'd0});
        cyc();

        // done on bank 0 while bank 1 queued
        pp_done = 1'b1; alloc_req = 1'b1; #1;
        check_val("done_cycle_gnt", alloc_gnt, 0);
        cyc();
        pp_done = 1'b0; #1;
        check_val("after_done_free", free_cnt, 1);
        check_val("after_done_gnt", alloc_gnt, 1);
        check_val("after_done_bank", alloc_bank, 0);
        check_val("after_done_valid", pp_cmd_valid, 0);
        cyc();
        alloc_req = 1'b0; #1;
        check_val("second_valid", pp_cmd_valid, 1);
        check_val("second_bank", pp_bank, 1);
        check_val("second_fields", {pp_flags, pp_scale, pp_shift}, {8'h21, 8'd5, 8'd6});
        check_val("second_free", free_cnt, 0);

        pp_cmd_ready = 1'b1;
        cyc();
        pp_cmd_ready = 1'b0; pp_done = 1'b1;
        cyc();
        pp_done = 1'b0; #1;
        check_val("second_done_free", free_cnt, 1);
        check_val("second_done_busy", sched_busy, 0);
        check_val("no_proto_yet", err_proto, 0);

        // handover naming a FREE bank
        set_tile(1'b1, 8'hAA, 8'd1, 8'd1);
        cyc();
        tile_valid = 1'b0; #1;
        check_val("proto_err", err_proto, 1);
        check_val("proto_busy", sched_busy, 0);
        check_val("proto_free", free_cnt, 1);
        cyc(); cyc();
        check_val("proto_no_issue", pp_cmd_valid, 0);
        check_val("proto_idle", sched_busy, 0);

        // watchdog: bank 0 still FILLING from the earlier grant
        set_tile(1'b0, 8'h11, 8'd1, 8'd2);
        cyc();
        tile_valid = 1'b0;
        cyc();
        check_val("wd_issue_valid", pp_cmd_valid, 1);
        check_val("wd_issue_flags", pp_flags, 8'h11);
        pp_cmd_ready = 1'b1;
        cyc();
        pp_cmd_ready = 1'b0;
        for (int i = 0; i < 15; i++) cyc();
        check_val("wd_before", err_timeout, 0);
        check_val("wd_before_busy", sched_busy, 1);
        cyc();
        check_val("wd_fired", err_timeout, 1);
        check_val("wd_free", free_cnt, 2);
        check_val("wd_idle", sched_busy, 0);
        check_val("wd_valid", pp_cmd_valid, 0);

        // flush: bank 0 running, bank 1 ready in queue
        alloc_req = 1'b1;
        cyc(); cyc();
        alloc_req = 1'b0; #1;
        check_val("fl_alloc_free", free_cnt, 0);
        set_tile(1'b0, 8'h41, 8'd0, 8'd0);
        cyc();
        set_tile(1'b1, 8'h42, 8'd0, 8'd0);
        cyc();
        tile_valid = 1'b0; #1;
        check_val("fl_issue_valid", pp_cmd_valid, 1);
        check_val("fl_issue_bank", pp_bank, 0);
        pp_cmd_ready = 1'b1;
        cyc();
        pp_cmd_ready = 1'b0;
        flush = 1'b1; #1;
        check_val("fl_tile_blocked", tile_ready, 0);
        cyc();
        flush = 1'b0; #1;
        check_val("fl_bank1_free", free_cnt, 1);
        check_val("fl_busy_run", sched_busy, 1);
        check_val("fl_flags_stable", pp_flags, 8'h41);
        cyc(); cyc();
        check_val("fl_no_issue", pp_cmd_valid, 0);
        check_val("fl_bank0_held", free_cnt, 1);
        pp_done = 1'b1;
        cyc();
        pp_done = 1'b0; #1;
        check_val("fl_done_free", free_cnt, 2);
        check_val("fl_done_busy", sched_busy, 0);
        cyc();
        check_val("fl_no_late_issue", pp_cmd_valid, 0);

        // reset clears sticky errors; done while IDLE is a protocol error
        rst = 1'b1;
        cyc();
        rst = 1'b0; #1;
        check_val("rst2_errs", {err_timeout, err_proto}, 0);
        check_val("rst2_fields", pp_flags, 0);
        pp_done = 1'b1;
        cyc();
        pp_done = 1'b0; #1;
        check_val("done_idle_proto", err_proto, 1);
        check_val("done_idle_free", free_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gemm_post_sched.md
Name: gemm_post_sched

Overview:
Scheduler that sequences the GEMM post-processing unit against a ping-pong pool of ACC SRAM banks. The GEMM engine allocates a free bank, accumulates a tile into it, then hands the tile's post-processing options (flags/scale/shift) to this block. Handed-over tiles are queued in order, issued one at a time to the post-processor with a valid/ready command, and the bank is freed when the post-processor signals done. The block sits between the GEMM engine, the ACC bank read mux and the post-processing unit.

Parameters:
NUM_BANKS, 2, number of ACC SRAM banks managed (2..4)
BANK_W, $clog2(NUM_BANKS), bank index width
QDEPTH, 4, pending-tile command queue depth (power of 2)
TIMEOUT, 4096, max cycles in RUN before the watchdog fires

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
alloc_req  in  1  GEMM requests a free ACC bank
alloc_gnt  out  1  grant; same-cycle (combinational) response to alloc_req
alloc_bank  out  BANK_W  granted bank index, valid with alloc_gnt
tile_valid  in  1  GEMM finished accumulating a tile
tile_ready  out  1  queue can accept a tile
tile_bank  in  BANK_W  bank holding the finished tile
tile_flags  in  8  post flags (bias/requant/relu bits per isa_pkg)
tile_scale  in  8  requant scale
tile_shift  in  8  requant shift
pp_cmd_valid  out  1  command to post-processor
pp_cmd_ready  in  1  post-processor accepts command
pp_flags / pp_scale / pp_shift  out  8 each  command fields, stable from ISSUE through RUN
pp_bank  out  BANK_W  selects the ACC bank read mux; stable from ISSUE through RUN
pp_done  in  1  single-cycle pulse when post-processing completes
flush  in  1  abort all queued/filling work
sched_busy  out  1  FSM not IDLE or queue non-empty
free_cnt  out  BANK_W+1  number of FREE banks
err_timeout  out  1  sticky watchdog error
err_proto  out  1  sticky protocol error

Behaviour:
- Reset: all banks FREE, queue empty, FSM IDLE, watchdog 0, all outputs 0 except free_cnt=NUM_BANKS and tile_ready=1. The reset value of every pp_* field is 0.
- Bank state per bank is FREE/FILLING/READY/DRAINING, held in registers.
- Allocate:
  - alloc_gnt = alloc_req & any FREE & !flush.
  - alloc_bank = lowest-index FREE bank.
  - On a grant, that bank becomes FILLING at the clock edge.
  - A requester holding alloc_req receives a new grant every cycle that a bank is free.
- Tile handover:
  - tile_ready = (count < QDEPTH) & !flush.
  - On accept, push {tile_bank, flags, scale, shift} and move the bank FILLING->READY.
  - If tile_bank is not FILLING: set err_proto, drop the entry, leave bank state unchanged.
- Issue FSM:
  - IDLE: if the queue is non-empty, pop the head into the pp_* registers, set bank DRAINING, go to ISSUE.
  - ISSUE: drive pp_cmd_valid=1. Once asserted, valid is never retracted. On pp_cmd_ready go to RUN.
  - RUN: clear the watchdog on entry and increment it each cycle. On pp_done: set bank FREE, go to IDLE. If the watchdog reaches TIMEOUT-1 without done: set err_timeout, set bank FREE, go to IDLE.
  - pp_done outside RUN sets err_proto and is otherwise ignored.
- Latency: pp_done to the next pp_cmd_valid is 2 cycles when the queue is non-empty. Tile accept to pp_cmd_valid with an idle FSM is 2 cycles.
- Simultaneous events:
  - A bank freed by pp_done in cycle N is grantable from cycle N+1. Grants use registered state only.
  - Push and pop in the same cycle is legal. Count stays unchanged.
- Flush (one-cycle pulse or level):
  - Clears the queue.
  - Every FILLING or READY bank becomes FREE.
  - A DRAINING bank and the ISSUE/RUN FSM are untouched; the in-flight command completes normally, then the bank is freed.
  - Grants and tile accepts are blocked while flush=1.
- Reset mid-operation returns everything to reset values. The post-processor is reset by its own domain.
- Error flags clear only on rst.

Decomposition:
- npu_pkg gets:
  - bank_state_t enum (FREE, FILLING, READY, DRAINING)
  - pp_cmd_t packed struct {bank, flags, scale, shift}
  - sched_state_t enum (IDLE, ISSUE, RUN)
- One sub-module, pp_cmd_fifo: generic synchronous FIFO of pp_cmd_t with depth QDEPTH, count output, same-cycle push/pop.
- Bank allocation, the FSM and the watchdog stay in gemm_post_sched.

Test Plan:
- Reset then alloc_req=1 for 3 cycles, NUM_BANKS=2 -> grants bank 0, then bank 1, then alloc_gnt=0; free_cnt 2->1->0.
- Fill bank 0, tile_valid with flags=0x07, scale=3, shift=4 -> pp_cmd_valid 2 cycles later with pp_bank=0, pp_flags=0x07, pp_scale=3, pp_shift=4; hold pp_cmd_ready=0 for 5 cycles -> valid and fields stay stable.
- Two tiles queued, pp_done on first -> second pp_cmd_valid exactly 2 cycles after done; bank 0 FREE and grantable the cycle after done.
- Tile handover with tile_bank pointing at a FREE bank -> err_proto=1, queue count unchanged, no command issued.
- Command accepted, no pp_done for TIMEOUT cycles (TIMEOUT=16 in bench) -> err_timeout=1 at cycle 16, bank freed, FSM IDLE.
- Bank 0 RUN, bank 1 READY, flush=1 for 1 cycle -> bank 1 FREE and queue empty immediately; bank 0 freed only on the later pp_done; sched_busy drops the cycle after.
